echo_arbiter: RTL and testbench

ECHO_ARBITER -- requirements
Module: echo_arbiter

---
 rtl/echo_arbiter.sv | 145 ++++++++++++++
 tb/tb_echo_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/echo_arbiter.sv
// Two-requester echo arbiter: stages one request per requester, grants the
// shared echo datapath round-robin, and records the granted requester id in a
// tag FIFO so that in-order responses return to whoever issued them.
module echo_arbiter #(
  parameter int TAGDEPTH = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        req0__ENA,
  input  logic [31:0] req0_v,
  output logic        req0__RDY,
  input  logic        req1__ENA,
  input  logic [31:0] req1_v,
  output logic        req1__RDY,
  output logic        out_echoReq__ENA,
  output logic [31:0] out_echoReq_v,
  input  logic        out_echoReq__RDY,
  input  logic        rsp__ENA,
  input  logic [31:0] rsp_v,
  output logic        rsp__RDY,
  output logic        ind0_echo__ENA,
  output logic [31:0] ind0_echo_v,
  input  logic        ind0_echo__RDY,
  output logic        ind1_echo__ENA,
  output logic [31:0] ind1_echo_v,
  input  logic        ind1_echo__RDY
);

  localparam int PW = (TAGDEPTH > 1) ? $clog2(TAGDEPTH) : 1;
  localparam int CW = $clog2(TAGDEPTH + 1);

  // Staging entries, one per requester
  logic [1:0]    valid_q, valid_d;
  logic [31:0]   data_q [2];
  logic [31:0]   data_d [2];
  logic [31:0]   req_v  [2];
  logic [1:0]    capture;

  // Round-robin pointer: requester that wins when both are valid
  logic          prio_q, prio_d;

  // Tag FIFO of requester ids in issue order
  logic          tag_mem_q [TAGDEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          full;
  logic          issue;
  logic          sel;
  logic          head;
  logic          pop;

  assign req_v[0] = req0_v;
  assign req_v[1] = req1_v;

  assign req0__RDY = ~valid_q[0];
  assign req1__RDY = ~valid_q[1];

  // Capture is gated by RDY so an ENA on a busy entry is silently dropped.
  assign capture[0] = req0__ENA & ~valid_q[0];
  assign capture[1] = req1__ENA & ~valid_q[1];

  // Full is judged on the pre-pop count: a response never frees a slot for
  // an issue in the same cycle.
  assign full  = (count_q == CW'(TAGDEPTH));
  assign issue = out_echoReq__RDY & ~full & (|valid_q);
  assign sel   = (valid_q[0] & valid_q[1]) ? prio_q : valid_q[1];

  assign out_echoReq__ENA = issue;
  assign out_echoReq_v    = issue ? data_q[sel] : '0;

  // Responses go to the oldest outstanding requester, if it can take one.
  assign head     = tag_mem_q[rd_ptr_q];
  assign rsp__RDY = (count_q != '0) & (head ? ind1_echo__RDY : ind0_echo__RDY);
  assign pop      = rsp__ENA & rsp__RDY;

  assign ind0_echo__ENA = pop & ~head;
  assign ind0_echo_v    = (pop & ~head) ? rsp_v : '0;
  assign ind1_echo__ENA = pop & head;
  assign ind1_echo_v    = (pop & head) ? rsp_v : '0;

  // Next-state: staging capture/clear, round-robin update, FIFO bookkeeping
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    valid_d  = valid_q;
    data_d   = data_q;
    prio_d   = prio_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    for (int i = 0; i < 2; i++) begin
      if (capture[i]) begin
        valid_d[i] = 1'b1;
        data_d[i]  = req_v[i];
      end
    end

    // The selected entry is valid, hence never the one being captured.
    if (issue) begin
      valid_d[sel] = 1'b0;
      prio_d       = ~sel;
      wr_ptr_d     = wr_ptr_q + PW'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    count_d = count_q + CW'(issue) - CW'(pop);
  end

  // Control and staging state with asynchronous clear
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q   <= '0;
      data_q[0] <= '0;
      data_q[1] <= '0;
      prio_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples its pre-edge inputs regardless of statement order.
      valid_q  <= valid_d;
      data_q   <= data_d;
      prio_q   <= prio_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tag storage write on issue
  always_ff @(posedge CLK) begin
    // NOTE: the tag array is left unreset; slots are only read while count
    // says they hold a pushed id, so clearing the pointers is sufficient.
    if (issue) begin
      tag_mem_q[wr_ptr_q] <= sel;
    end
  end

endmodule

// File: tb/tb_echo_arbiter.sv
// Self-checking bench for echo_arbiter: a queue-based reference model is
// compared against every output on each falling edge, while directed
// scenarios pin known literal values at specific cycles.
module tb_echo_arbiter;

  localparam int TAGDEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_ena, r1_ena, o_rdy, rsp_ena, i0_rdy, i1_rdy;
  logic [31:0] r0_v, r1_v, rsp_v;
  logic        r0_rdy, r1_rdy, o_ena, rsp_rdy, i0_ena, i1_ena;
  logic [31:0] o_v, i0_v, i1_v;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          mv [2];
  logic [31:0] md [2];
  bit          mprio;
  int          tagq [$];
  logic [31:0] out_log [$];

  int  m_n, m_sel, m_head;
  bit  m_issue, m_rsprdy, m_deliver, m_cap0, m_cap1;

  always #5 clk = ~clk;

  echo_arbiter #(.TAGDEPTH(TAGDEPTH)) dut (
    .CLK              (clk),
    .nRST             (rst_n),
    .req0__ENA        (r0_ena),
    .req0_v           (r0_v),
    .req0__RDY        (r0_rdy),
    .req1__ENA        (r1_ena),
    .req1_v           (r1_v),
    .req1__RDY        (r1_rdy),
    .out_echoReq__ENA (o_ena),
    .out_echoReq_v    (o_v),
    .out_echoReq__RDY (o_rdy),
    .rsp__ENA         (rsp_ena),
    .rsp_v            (rsp_v),
    .rsp__RDY         (rsp_rdy),
    .ind0_echo__ENA   (i0_ena),
    .ind0_echo_v      (i0_v),
    .ind0_echo__RDY   (i0_rdy),
    .ind1_echo__ENA   (i1_ena),
    .ind1_echo_v      (i1_v),
    .ind1_echo__RDY   (i1_rdy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model compare and advance, once per cycle on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      mv[0] = 1'b0; mv[1] = 1'b0; md[0] = '0; md[1] = '0;
      mprio = 1'b0;
      tagq.delete();
      check("rst_req0_rdy", r0_rdy, 1);
      check("rst_req1_rdy", r1_rdy, 1);
      check("rst_rsp_rdy",  rsp_rdy, 0);
      check("rst_out_ena",  o_ena, 0);
      check("rst_out_v",    o_v, 0);
      check("rst_ind0_ena", i0_ena, 0);
      check("rst_ind1_ena", i1_ena, 0);
    end else begin
      m_n       = tagq.size();
      m_issue   = o_rdy && (m_n < TAGDEPTH) && (mv[0] || mv[1]);
      m_sel     = (mv[0] && mv[1]) ? int'(mprio) : (mv[1] ? 1 : 0);
      m_head    = (m_n > 0) ? tagq[0] : 0;
      m_rsprdy  = (m_n > 0) && ((m_head == 1) ? i1_rdy : i0_rdy);
      m_deliver = rsp_ena && m_rsprdy;

      check("m_req0_rdy", r0_rdy, !mv[0]);
      check("m_req1_rdy", r1_rdy, !mv[1]);
      check("m_out_ena",  o_ena, m_issue);
      check("m_out_v",    o_v, m_issue ? md[m_sel] : 32'h0);
      check("m_rsp_rdy",  rsp_rdy, m_rsprdy);
      check("m_ind0_ena", i0_ena, m_deliver && m_head == 0);
      check("m_ind0_v",   i0_v, (m_deliver && m_head == 0) ? rsp_v : 32'h0);
      check("m_ind1_ena", i1_ena, m_deliver && m_head == 1);
      check("m_ind1_v",   i1_v, (m_deliver && m_head == 1) ? rsp_v : 32'h0);

      if (o_ena) out_log.push_back(o_v);

      m_cap0 = r0_ena && !mv[0];
      m_cap1 = r1_ena && !mv[1];
      if (m_deliver) void'(tagq.pop_front());
      if (m_issue) begin
        tagq.push_back(m_sel);
        mv[m_sel] = 1'b0;
        mprio = (m_sel == 0);
      end
      if (m_cap0) begin mv[0] = 1'b1; md[0] = r0_v; end
      if (m_cap1) begin mv[1] = 1'b1; md[1] = r1_v; end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    r0_ena = 0; r0_v = '0; r1_ena = 0; r1_v = '0;
    rsp_ena = 0; rsp_v = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle();
    o_rdy = 1; i0_rdy = 1; i1_rdy = 1;
    tick();
    tick();
    rst_n = 1;
  endtask

  // Watchdog: never let the run hang
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed scenarios
  initial begin
    int base;
    int got;

    rst_n = 0;
    idle();
    o_rdy = 1; i0_rdy = 1; i1_rdy = 1;
    #2;
    check("por_req0_rdy", r0_rdy, 1);
    check("por_rsp_rdy",  rsp_rdy, 0);
    check("por_out_ena",  o_ena, 0);
    tick();
    tick();
    rst_n = 1;

    // Single request round trip
    do_reset();
    r0_ena = 1; r0_v = 32'h11;
    #1;
    check("single_req0_rdy_c1", r0_rdy, 1);
    check("single_out_ena_c1", o_ena, 0);
    tick();
    idle();
    #1;
    check("single_out_ena_c2", o_ena, 1);
    check("single_out_v_c2", o_v, 32'h11);
    check("single_req0_busy_c2", r0_rdy, 0);
    tick();
    #1;
    check("single_out_ena_c3", o_ena, 0);
    check("single_rsp_rdy_c3", rsp_rdy, 1);
    check("single_req0_free_c3", r0_rdy, 1);
    tick();
    tick();
    rsp_ena = 1; rsp_v = 32'h11;
    #1;
    check("single_ind0_ena", i0_ena, 1);
    check("single_ind0_v", i0_v, 32'h11);
    check("single_ind1_ena", i1_ena, 0);
    check("single_ind1_v", i1_v, 0);
    tick();
    rsp_ena = 0;
    #1;
    check("single_rsp_rdy_empty", rsp_rdy, 0);
    tick();

    // Contention with prio at its reset value
    do_reset();
    r0_ena = 1; r0_v = 32'hA0; r1_ena = 1; r1_v = 32'hB1;
    tick();
    idle();
    #1;
    check("cont_out_ena_1", o_ena, 1);
    check("cont_out_v_1", o_v, 32'hA0);
    tick();
    #1;
    check("cont_out_ena_2", o_ena, 1);
    check("cont_out_v_2", o_v, 32'hB1);
    tick();
    #1;
    check("cont_out_ena_3", o_ena, 0);
    rsp_ena = 1; rsp_v = 32'hA0;
    #1;
    check("cont_ind0_ena", i0_ena, 1);
    check("cont_ind0_v", i0_v, 32'hA0);
    check("cont_ind1_ena_a", i1_ena, 0);
    tick();
    rsp_v = 32'hB1;
    #1;
    check("cont_ind1_ena", i1_ena, 1);
    check("cont_ind1_v", i1_v, 32'hB1);
    check("cont_ind0_ena_b", i0_ena, 0);
    tick();
    idle();
    tick();

    // Fairness: both refill every other cycle, responses always accepted
    do_reset();
    rsp_ena = 1; rsp_v = 32'hC0DE;
    base = out_log.size();
    for (int k = 0; k < 200 && (out_log.size() - base) < 20; k++) begin
      if (k % 2 == 0) begin
        r0_ena = 1; r0_v = 32'h100 | k;
        r1_ena = 1; r1_v = 32'h200 | k;
      end else begin
        r0_ena = 0; r1_ena = 0;
      end
      tick();
    end
    idle();
    got = out_log.size() - base;
    check("fair_count", (got >= 20) ? 20 : got, 20);
    for (int i = 0; i < 20; i++) begin
      if (base + i < out_log.size())
        check($sformatf("fair_grant%0d", i), out_log[base + i][9], i % 2);
    end
    tick();

    // Tag FIFO full blocks issue until a response frees a slot
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      r0_ena = 1; r0_v = k;
      tick();
      r0_ena = 0;
      tick();
    end
    r0_ena = 1; r0_v = 32'h5;
    tick();
    r0_ena = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("full_out_blocked%0d", k), o_ena, 0);
      check($sformatf("full_req0_busy%0d", k), r0_rdy, 0);
      tick();
    end
    rsp_ena = 1; rsp_v = 32'h1;
    #1;
    check("full_ind0_ena", i0_ena, 1);
    check("full_no_same_cycle_issue", o_ena, 0);
    tick();
    rsp_ena = 0;
    #1;
    check("full_issue_after_pop", o_ena, 1);
    check("full_issue_v", o_v, 32'h5);
    tick();
    #1;
    check("full_req0_free", r0_rdy, 1);
    tick();

    // Backpressure from requester 1's indication port
    do_reset();
    r1_ena = 1; r1_v = 32'h77;
    tick();
    r1_ena = 0;
    tick();
    i1_rdy = 0;
    rsp_ena = 1; rsp_v = 32'h77;
    #1;
    check("bp_rsp_rdy", rsp_rdy, 0);
    check("bp_ind1_ena", i1_ena, 0);
    check("bp_ind0_ena", i0_ena, 0);
    tick();
    #1;
    check("bp_rsp_rdy_held", rsp_rdy, 0);
    i1_rdy = 1;
    #1;
    check("bp_rsp_rdy_release", rsp_rdy, 1);
    check("bp_ind1_ena_release", i1_ena, 1);
    check("bp_ind1_v_release", i1_v, 32'h77);
    tick();
    rsp_ena = 0;
    #1;
    check("bp_drained", rsp_rdy, 0);
    tick();

    // Reset mid-operation discards staged and outstanding work
    do_reset();
    r0_ena = 1; r0_v = 32'hAA; r1_ena = 1; r1_v = 32'hBB;
    tick();
    idle();
    tick();
    tick();
    o_rdy = 0;
    r1_ena = 1; r1_v = 32'h33;
    tick();
    r1_ena = 0;
    #1;
    check("mid_req1_staged", r1_rdy, 0);
    check("mid_rsp_rdy_outstanding", rsp_rdy, 1);
    #1;
    rst_n = 0;
    #1;
    check("mid_rst_req0_rdy", r0_rdy, 1);
    check("mid_rst_req1_rdy", r1_rdy, 1);
    check("mid_rst_rsp_rdy", rsp_rdy, 0);
    check("mid_rst_out_ena", o_ena, 0);
    check("mid_rst_out_v", o_v, 0);
    check("mid_rst_ind0_ena", i0_ena, 0);
    check("mid_rst_ind1_ena", i1_ena, 0);
    tick();
    tick();
    rst_n = 1;
    o_rdy = 1;
    rsp_ena = 1; rsp_v = 32'h44;
    #1;
    check("post_rst_rsp_rdy", rsp_rdy, 0);
    check("post_rst_ind0_ena", i0_ena, 0);
    check("post_rst_ind1_ena", i1_ena, 0);
    check("post_rst_out_ena", o_ena, 0);
    tick();
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
